// File: rtl/adder_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl_if
// Stream bundle between the feature-data source, the sequencing controller and
// the layer-output buffer.
//   in_valid / in_ready / in_data         : sample stream into the controller
//   out_valid / out_ready / out_data /
//   out_last                              : result stream out of the controller
// Modports:
//   master : the environment (drives samples, accepts results)
//   slave  : the controller (accepts samples, presents results)
// -----------------------------------------------------------------------------
interface adder_seq_ctrl_if #(
  parameter int DATAWIDTH = 8,
  parameter int RESULT    = 10
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [RESULT-1:0]    out_data;
  logic                        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
// Sequencing controller for the three-input signed adder of the CNN datapath.
// Keeps a 3-deep sliding window of incoming samples, feeds the window to the
// external registered adder whenever it holds three fresh samples, and presents
// each sum on a valid/ready stream with a last flag. One pass of num_in_i
// samples (num_in_i - 2 results) is performed per accepted start command.
//
// Ports:
//   clk_i       : clock, all logic on the rising edge
//   rst_i       : synchronous active-high reset
//   start_i     : one-cycle start command, honoured only when idle
//   num_in_i    : samples in the pass, latched on an honoured start
//   busy_o      : high whenever a pass is in progress
//   done_o      : one-cycle pulse after the final result is taken
//   cfg_err_o   : one-cycle pulse when a start is rejected (num_in_i < 3)
//   add_d1_o    : adder operand, oldest sample
//   add_d2_o    : adder operand, middle sample
//   add_d3_o    : adder operand, newest sample
//   add_sum_i   : registered adder result (one-cycle latency)
//   strm        : sample/result streams (slave side)
// -----------------------------------------------------------------------------
module adder_seq_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int RESULT    = 10,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            num_in_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_err_o,
  output logic signed [DATAWIDTH-1:0] add_d1_o,
  output logic signed [DATAWIDTH-1:0] add_d2_o,
  output logic signed [DATAWIDTH-1:0] add_d3_o,
  input  logic signed [RESULT-1:0]    add_sum_i,
  adder_seq_ctrl_if.slave             strm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                      state_q,     state_d;
  logic [CNT_W-1:0]            num_q,       num_d;
  logic [CNT_W-1:0]            cnt_in_q,    cnt_in_d;
  logic [CNT_W-1:0]            cnt_out_q,   cnt_out_d;
  logic signed [DATAWIDTH-1:0] w_old_q,     w_old_d;
  logic signed [DATAWIDTH-1:0] w_mid_q,     w_mid_d;
  logic signed [DATAWIDTH-1:0] w_new_q,     w_new_d;
  logic                        pend_q,      pend_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q,  out_last_d;
  logic                        busy_q,      busy_d;
  logic                        done_q,      done_d;
  logic                        cfg_err_q,   cfg_err_d;

  logic in_ready_s;
  logic accept_s;
  logic hs_s;

  // Sample acceptance: blocked while a sum is in the adder stage, and while a
  // presented result is stalled so the window (and thus add_sum) stays frozen.
  always_comb begin
    in_ready_s = ((state_q == S_FILL) || (state_q == S_RUN)) && !pend_q &&
                 (!out_valid_q || strm.out_ready);
    accept_s   = strm.in_valid && in_ready_s;
    hs_s       = out_valid_q && strm.out_ready;
  end

  // Next-state and datapath-control logic.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    cnt_in_d    = cnt_in_q;
    cnt_out_d   = cnt_out_q;
    w_old_d     = w_old_q;
    w_mid_d     = w_mid_q;
    w_new_d     = w_new_q;
    pend_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    // Window shift and input count on every accepted sample.
    if (accept_s) begin
      w_old_d  = w_mid_q;
      w_mid_d  = w_new_q;
      w_new_d  = strm.in_data;
      cnt_in_d = cnt_in_q + CNT_W'(1);
    end else begin
      cnt_in_d = cnt_in_q;
    end

    // Result taken downstream.
    if (hs_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_out_d   = cnt_out_q + CNT_W'(1);
    end else begin
      cnt_out_d   = cnt_out_q;
    end

    // The adder register has captured the window: present the sum. A pending
    // sum always follows a taken (or absent) result, so cnt_out_q + 1 is the
    // number of this result; it is the last one when it equals num - 2.
    if (pend_q) begin
      out_valid_d = 1'b1;
      out_last_d  = ((cnt_out_q + CNT_W'(3)) == num_q);
    end else begin
      out_valid_d = out_valid_d;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_in_i >= CNT_W'(3)) begin
            num_d     = num_in_i;
            cnt_in_d  = {CNT_W{1'b0}};
            cnt_out_d = {CNT_W{1'b0}};
            state_d   = S_FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        // Third sample completes the window; a 3-sample pass needs no more input.
        if (accept_s && (cnt_in_q == CNT_W'(2))) begin
          pend_d  = 1'b1;
          state_d = ((cnt_in_q + CNT_W'(1)) == num_q) ? S_FLUSH : S_RUN;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          pend_d = 1'b1;
          if ((cnt_in_q + CNT_W'(1)) == num_q) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (hs_s && out_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset; reset aborts a pass.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      num_q       <= {CNT_W{1'b0}};
      cnt_in_q    <= {CNT_W{1'b0}};
      cnt_out_q   <= {CNT_W{1'b0}};
      w_old_q     <= {DATAWIDTH{1'b0}};
      w_mid_q     <= {DATAWIDTH{1'b0}};
      w_new_q     <= {DATAWIDTH{1'b0}};
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cnt_in_q    <= cnt_in_d;
      cnt_out_q   <= cnt_out_d;
      w_old_q     <= w_old_d;
      w_mid_q     <= w_mid_d;
      w_new_q     <= w_new_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Output drive; out_data is the adder result passed through untouched.
  always_comb begin
    busy_o         = busy_q;
    done_o         = done_q;
    cfg_err_o      = cfg_err_q;
    add_d1_o       = w_old_q;
    add_d2_o       = w_mid_q;
    add_d3_o       = w_new_q;
    strm.in_ready  = in_ready_s;
    strm.out_valid = out_valid_q;
    strm.out_last  = out_last_q;
    strm.out_data  = add_sum_i;
  end

endmodule
